uart_char_stream: RTL and testbench
===================================

# uart_char_stream

Parametrised UART character-stream transmitter: it generates an ASCII run from FIRST_CHAR to LAST_CHAR, optionally terminated by CR LF, and serialises each character with a configurable frame format. It succeeds the fixed 8N1 "a–z every half second" chain, which was built from a pulse generator, a letter generator and a UART. This block merges character generation, framing and line pacing into one FSM, adding parity, 2 stop bits, narrow words, line gap and one-shot mode. It sits directly between the board clock and the TX pin in top-level designs.

## Interface
- FREQ_IN, 12000000: hclk frequency in Hz.
- BAUD, 9600: bit rate; DIV = FREQ_IN/BAUD (integer division, DIV ≥ 2 required).
- DATA_BITS, 8: data bits per frame, legal range 5–8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIRST_CHAR, 8'h61: first character of a line.
- LAST_CHAR, 8'h7A: last character of a line; FIRST_CHAR ≤ LAST_CHAR required.
- APPEND_CRLF, 1: 1 = send 8'h0D then 8'h0A after LAST_CHAR.
- GAP_CYCLES, 6000000: idle hclk cycles after each line; 0 = no gap.

Ports:
- hclk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: run request.
- one_shot, in, 1: 1 = one line per enable assertion; 0 = lines repeat while enable is high.
- tx, out, 1: serial output, idles high.
- busy, out, 1: high while a line is being framed.
- word, out, 8: character of the current or most recent frame.
- line_done, out, 1: one-cycle pulse after the last stop bit of a line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- All bit periods are exactly DIV cycles. The baud counter is cleared on entry to START, so there is no drift across frames.
- IDLE:
  - Pointer = FIRST_CHAR.
  - Move to START when enable = 1 and armed = 1.
  - armed is set when enable = 0 and cleared when a one-shot line completes.
- START: tx = 0; word ← current character.
- DATA:
  - Bits word[0] .. word[DATA_BITS-1], LSB first.
  - Unused high bits are still shown on word but are not sent.
- PARITY: entered only if PARITY ≠ 0. The bit is XOR of the sent bits; it is inverted for odd parity.
- STOP: tx = 1 for STOP_BITS × DIV cycles. Then:
  - If the line is incomplete, go to START with the next character, with zero idle cycles between frames.
  - After LAST_CHAR, if APPEND_CRLF = 1, the next characters are 0x0D then 0x0A.
  - If the line is complete: pulse line_done and enter GAP.
- GAP: tx = 1, busy = 0 for GAP_CYCLES cycles. Then:
  - If one_shot = 1 (sampled at GAP exit): go to IDLE and clear armed.
  - Otherwise go to IDLE, which restarts immediately if enable is still 1.
- enable falling mid-line:
  - The current frame completes in full; no truncated frames.
  - Then go to IDLE, reset the pointer, and emit no line_done.
- Arithmetic:
  - Pointer is 8-bit; it increments only from FIRST_CHAR up to LAST_CHAR and never wraps.
  - Baud counter width is clog2(DIV); gap counter width is clog2(GAP_CYCLES+1).

## Timing
- Reset values: tx = 1, busy = 0, word = 8'h00, line_done = 0, state IDLE, pointer = FIRST_CHAR, armed = 1.
- Reset mid-frame takes effect at the next edge; tx goes high immediately, with no completion of the frame.
- Latency: enable sampled high in IDLE → tx = 0 and busy = 1 on the following cycle.
- Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- busy:
  - Rises with the first start bit.
  - Stays high across all characters of the line.
  - Falls in the same cycle line_done is high.
- line_done is high for exactly 1 cycle: the first cycle after the final stop bit.
- Line period with enable held high and one_shot = 0 = N_chars × frame + GAP_CYCLES + 1 cycles, where the +1 is the IDLE cycle.

## Test plan
Simulation parameters unless noted: FREQ_IN = 100, BAUD = 50 (DIV = 2), FIRST_CHAR = 'a', LAST_CHAR = 'c', APPEND_CRLF = 1, GAP_CYCLES = 10, 8N1.

- Single frame: enable = 1 → tx carries 0x61 as bits 0,1,0,0,0,0,1,1,0,1, each 2 cycles (20 cycles); word = 0x61 from the start bit.
- Full line: enable held high → bytes 61, 62, 63, 0D, 0A back to back; busy high 100 cycles; one line_done pulse; tx high for 10 gap cycles plus 1 idle cycle; next start bit at cycle 112.
- Parity and stop bits: PARITY = 2, STOP_BITS = 2 → 0x61 parity bit = 1; frame 24 cycles. With PARITY = 1 the parity bit = 0. With DATA_BITS = 7 only 7 data bits are sent (frame 22 cycles at 7E2).
- One-shot: one_shot = 1, enable held high → exactly one line, then idle indefinitely. Drop enable for 1 cycle and re-raise it → a second line starts 1 cycle later.
- Abort: enable = 0 during the data bits of 'b' → the 'b' frame completes, then tx idles; no line_done. Re-enable → the line restarts at 'a'.
- Reset: rst = 1 for 1 cycle during the stop bit of 'c' → next cycle tx = 1, busy = 0, word = 0x00; with enable high, the line restarts at 'a' after reset release.

Source files
------------

// File: rtl/uart_char_stream_if.sv
// Bundles the run controls and serial/status outputs of uart_char_stream.
// master: the side that requests lines and observes the line.
// slave: the transmitter itself.
interface uart_char_stream_if;
  logic       enable;
  logic       one_shot;
  logic       tx;
  logic       busy;
  logic [7:0] word;
  logic       line_done;

  modport master (output enable, one_shot, input tx, busy, word, line_done);
  modport slave  (input enable, one_shot, output tx, busy, word, line_done);
endinterface

// File: rtl/uart_char_stream.sv
// Purpose: emits an ASCII run FIRST_CHAR..LAST_CHAR (+ optional CR LF) as configurable UART frames.
// Latency: enable seen high in IDLE -> start bit on tx the following cycle; frames run back to back.
// Backpressure: none; enable is the only throttle and a frame in flight is always completed.
module uart_char_stream #(
  parameter int         FREQ_IN     = 12000000,
  parameter int         BAUD        = 9600,
  parameter int         DATA_BITS   = 8,
  parameter int         PARITY      = 0,
  parameter int         STOP_BITS   = 1,
  parameter logic [7:0] FIRST_CHAR  = 8'h61,
  parameter logic [7:0] LAST_CHAR   = 8'h7A,
  parameter int         APPEND_CRLF = 1,
  parameter int         GAP_CYCLES  = 6000000
) (
  input  logic              hclk,
  input  logic              rst,
  uart_char_stream_if.slave bus
);

  localparam int DIV    = FREQ_IN / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]        DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_ptr;
  logic [1:0]         r_crlf;   // 0: letters, 1: sending CR, 2: sending LF
  logic [7:0]         r_word;
  logic               r_armed;
  logic               r_line_done;

  state_t     w_state_nxt;
  logic       w_bit_end;
  logic       w_last_char;
  logic       w_next_frame;
  logic       w_line_end;
  logic       w_disarm;
  logic [7:0] w_adv_ptr;
  logic [1:0] w_adv_crlf;
  logic [7:0] w_adv_char;
  logic       w_parity;
  logic       w_tx;
  logic       w_busy;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_last_char = (APPEND_CRLF != 0) ? (r_crlf == 2'd2) : (r_ptr == LAST_CHAR);
  assign w_parity    = (^(r_word & DATA_MASK)) ^ (PARITY == 1);

  // Next character of the line: letters up to LAST_CHAR (no wrap), then CR, then LF.
  always_comb begin
    w_adv_ptr  = r_ptr;
    w_adv_crlf = r_crlf;
    if (r_crlf == 2'd0 && r_ptr != LAST_CHAR) begin
      w_adv_ptr = r_ptr + 8'd1;
    end else if (r_crlf != 2'd2) begin
      w_adv_crlf = r_crlf + 2'd1;
    end
    case (w_adv_crlf)
      2'd0:    w_adv_char = w_adv_ptr;
      2'd1:    w_adv_char = 8'h0D;
      default: w_adv_char = 8'h0A;
    endcase
  end

  // Next-state logic and the Moore outputs tx/busy.
  always_comb begin
    w_state_nxt  = r_state;
    w_next_frame = 1'b0;
    w_line_end   = 1'b0;
    w_disarm     = 1'b0;
    w_tx         = 1'b1;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && r_armed) w_state_nxt = S_START;
      end
      S_START: begin
        w_tx   = 1'b0;
        w_busy = 1'b1;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx   = r_word[r_bit];
        w_busy = 1'b1;
        if (w_bit_end && r_bit == DATA_LAST) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx   = w_parity;
        w_busy = 1'b1;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_busy = 1'b1;
        if (w_bit_end && r_bit == STOP_LAST) begin
          if (w_last_char) begin
            // A fully sent line counts as complete even if enable just dropped.
            w_line_end = 1'b1;
            if (GAP_CYCLES == 0) begin
              w_state_nxt = S_IDLE;
              w_disarm    = bus.one_shot;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else if (!bus.enable) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt  = S_START;
            w_next_frame = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_disarm    = bus.one_shot;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus bit timing, character pointer and arming.
  always_ff @(posedge hclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit       <= 3'd0;
      r_gap       <= '0;
      r_ptr       <= FIRST_CHAR;
      r_crlf      <= 2'd0;
      r_word      <= 8'h00;
      r_armed     <= 1'b1;
      r_line_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_line_done <= w_line_end;

      // Every state change (including entry to START) restarts the bit period.
      if (w_bit_end || w_state_nxt != r_state) r_baud <= '0;
      else                                     r_baud <= r_baud + BAUD_W'(1);

      if (w_state_nxt != r_state)                                 r_bit <= 3'd0;
      else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP)) r_bit <= r_bit + 3'd1;

      if (r_state == S_GAP) r_gap <= r_gap + GAP_W'(1);
      else                  r_gap <= '0;

      if (w_state_nxt == S_IDLE) begin
        r_ptr  <= FIRST_CHAR;
        r_crlf <= 2'd0;
      end else if (w_next_frame) begin
        r_ptr  <= w_adv_ptr;
        r_crlf <= w_adv_crlf;
      end

      if (r_state == S_IDLE && w_state_nxt == S_START) r_word <= r_ptr;
      else if (w_next_frame)                           r_word <= w_adv_char;

      // Dropping enable re-arms; a finished one-shot line disarms until then.
      if (!bus.enable)   r_armed <= 1'b1;
      else if (w_disarm) r_armed <= 1'b0;
    end
  end

  assign bus.tx        = w_tx;
  assign bus.busy      = w_busy;
  assign bus.word      = r_word;
  assign bus.line_done = r_line_done;

endmodule

// File: tb/tb_uart_char_stream.sv
// Directed bench for uart_char_stream: 8N1 main instance plus 8E2, 8O2 and 7E2 instances.
// DIV = 2, line 'a'..'c' + CR LF, 10-cycle gap.
module tb_uart_char_stream;

  logic hclk = 1'b0;
  logic rst  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  uart_char_stream_if m_if ();
  uart_char_stream_if e_if ();
  uart_char_stream_if o_if ();
  uart_char_stream_if s_if ();

  uart_char_stream #(.FREQ_IN(100), .BAUD(50), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIRST_CHAR(8'h61), .LAST_CHAR(8'h63), .APPEND_CRLF(1), .GAP_CYCLES(10))
    u_dut (.hclk(hclk), .rst(rst), .bus(m_if));

  uart_char_stream #(.FREQ_IN(100), .BAUD(50), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
    .FIRST_CHAR(8'h61), .LAST_CHAR(8'h63), .APPEND_CRLF(1), .GAP_CYCLES(10))
    u_even (.hclk(hclk), .rst(rst), .bus(e_if));

  uart_char_stream #(.FREQ_IN(100), .BAUD(50), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
    .FIRST_CHAR(8'h61), .LAST_CHAR(8'h63), .APPEND_CRLF(1), .GAP_CYCLES(10))
    u_odd (.hclk(hclk), .rst(rst), .bus(o_if));

  uart_char_stream #(.FREQ_IN(100), .BAUD(50), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
    .FIRST_CHAR(8'h61), .LAST_CHAR(8'h63), .APPEND_CRLF(1), .GAP_CYCLES(10))
    u_seven (.hclk(hclk), .rst(rst), .bus(s_if));

  always #5 hclk = ~hclk;

  // Captured samples of the main instance, index = cycles since the first start bit.
  logic       s_tx   [0:399];
  logic       s_busy [0:399];
  logic       s_ld   [0:399];
  logic [7:0] s_word [0:399];

  // Hand-derived frames in send order (leftmost bit first), one bit per baud period.
  logic [11:0] fr_a, fr_b, fr_c, fr_cr, fr_lf, fr_8e2, fr_8o2, fr_7e2;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_if.enable = 1'b0; m_if.one_shot = 1'b0;
    e_if.enable = 1'b0; e_if.one_shot = 1'b0;
    o_if.enable = 1'b0; o_if.one_shot = 1'b0;
    s_if.enable = 1'b0; s_if.one_shot = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Records n cycles of the main instance; drops enable right after sample drop_at.
  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      s_tx[i]   = m_if.tx;
      s_busy[i] = m_if.busy;
      s_ld[i]   = m_if.line_done;
      s_word[i] = m_if.word;
      if (i == drop_at) m_if.enable = 1'b0;
      tick();
    end
  endtask

  // Expands an nbit frame to two samples per bit (DIV = 2).
  function automatic logic [23:0] dbl(input logic [11:0] v, input int nbit);
    logic [23:0] r;
    r = '0;
    for (int b = 0; b < nbit; b++) begin
      r[2*b]   = v[b];
      r[2*b+1] = v[b];
    end
    return r;
  endfunction

  function automatic logic [23:0] obs_frame(input int base, input int len);
    logic [23:0] r;
    r = '0;
    for (int j = 0; j < len; j++) r = {r[22:0], s_tx[base+j]};
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_if.tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", m_if.tx); end
    n_cmp++; if (m_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", m_if.busy); end
    n_cmp++; if (m_if.word !== 8'h00) begin n_err++; $display("FAIL reset_word got %h want 00", m_if.word); end
    n_cmp++; if (m_if.line_done !== 1'b0) begin n_err++; $display("FAIL reset_line_done got %b want 0", m_if.line_done); end
  endtask

  task automatic test_single_frame();
    logic [23:0] obs;
    do_reset();
    m_if.enable = 1'b1;
    tick();
    capture(20, -1);
    obs = obs_frame(0, 20);
    n_cmp++; if (obs !== dbl(fr_a, 10)) begin n_err++; $display("FAIL single_frame_bits got %h want %h", obs, dbl(fr_a, 10)); end
    n_cmp++; if (s_word[0] !== 8'h61) begin n_err++; $display("FAIL single_word_start got %h want 61", s_word[0]); end
    n_cmp++; if (s_busy[0] !== 1'b1) begin n_err++; $display("FAIL single_busy_start got %b want 1", s_busy[0]); end
  endtask

  task automatic test_full_line();
    logic [11:0] fr [5];
    logic [7:0]  ch [5];
    logic [23:0] obs;
    int          cnt_busy, cnt_gap_busy, cnt_gap_txlo, cnt_ld;
    fr = '{fr_a, fr_b, fr_c, fr_cr, fr_lf};
    ch = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
    do_reset();
    m_if.enable = 1'b1;
    tick();
    capture(112, -1);
    for (int k = 0; k < 5; k++) begin
      obs = obs_frame(20*k, 20);
      n_cmp++; if (obs !== dbl(fr[k], 10)) begin n_err++; $display("FAIL line_frame%0d got %h want %h", k, obs, dbl(fr[k], 10)); end
      n_cmp++; if (s_word[20*k] !== ch[k]) begin n_err++; $display("FAIL line_word%0d got %h want %h", k, s_word[20*k], ch[k]); end
    end
    cnt_busy = 0; cnt_gap_busy = 0; cnt_gap_txlo = 0; cnt_ld = 0;
    for (int i = 0; i < 100; i++) if (s_busy[i] === 1'b1) cnt_busy++;
    for (int i = 100; i < 111; i++) begin
      if (s_busy[i] !== 1'b0) cnt_gap_busy++;
      if (s_tx[i] !== 1'b1) cnt_gap_txlo++;
    end
    for (int i = 0; i < 112; i++) if (s_ld[i] === 1'b1) cnt_ld++;
    n_cmp++; if (cnt_busy !== 100) begin n_err++; $display("FAIL line_busy_cycles got %0d want 100", cnt_busy); end
    n_cmp++; if (cnt_gap_busy !== 0) begin n_err++; $display("FAIL gap_busy_cycles got %0d want 0", cnt_gap_busy); end
    n_cmp++; if (cnt_gap_txlo !== 0) begin n_err++; $display("FAIL gap_tx_low_cycles got %0d want 0", cnt_gap_txlo); end
    n_cmp++; if (cnt_ld !== 1) begin n_err++; $display("FAIL line_done_count got %0d want 1", cnt_ld); end
    n_cmp++; if (s_ld[100] !== 1'b1) begin n_err++; $display("FAIL line_done_pos got %b want 1 at sample 100", s_ld[100]); end
    n_cmp++; if (s_tx[111] !== 1'b0 || s_busy[111] !== 1'b1) begin n_err++; $display("FAIL next_line_start got tx=%b busy=%b want tx=0 busy=1", s_tx[111], s_busy[111]); end
    n_cmp++; if (s_word[111] !== 8'h61) begin n_err++; $display("FAIL next_line_word got %h want 61", s_word[111]); end
  endtask

  task automatic test_parity();
    logic [23:0] oe, oo, os;
    logic [7:0]  we, ws;
    logic        te, ts;
    do_reset();
    e_if.enable = 1'b1; o_if.enable = 1'b1; s_if.enable = 1'b1;
    tick();
    oe = '0; oo = '0; os = '0; we = 8'h00; ws = 8'h00; te = 1'b1; ts = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i < 24) begin oe = {oe[22:0], e_if.tx}; oo = {oo[22:0], o_if.tx}; end
      if (i < 22) os = {os[22:0], s_if.tx};
      if (i == 22) begin ts = s_if.tx; ws = s_if.word; end
      if (i == 24) begin te = e_if.tx; we = e_if.word; end
      tick();
    end
    n_cmp++; if (oe !== dbl(fr_8e2, 12)) begin n_err++; $display("FAIL even_8e2_bits got %h want %h", oe, dbl(fr_8e2, 12)); end
    n_cmp++; if (oo !== dbl(fr_8o2, 12)) begin n_err++; $display("FAIL odd_8o2_bits got %h want %h", oo, dbl(fr_8o2, 12)); end
    n_cmp++; if (os !== dbl(fr_7e2, 11)) begin n_err++; $display("FAIL even_7e2_bits got %h want %h", os, dbl(fr_7e2, 11)); end
    n_cmp++; if (te !== 1'b0 || we !== 8'h62) begin n_err++; $display("FAIL 8e2_len24 got tx=%b word=%h want tx=0 word=62", te, we); end
    n_cmp++; if (ts !== 1'b0 || ws !== 8'h62) begin n_err++; $display("FAIL 7e2_len22 got tx=%b word=%h want tx=0 word=62", ts, ws); end
  endtask

  task automatic test_one_shot();
    int cnt_busy, cnt_ld, cnt_late;
    do_reset();
    m_if.one_shot = 1'b1;
    m_if.enable   = 1'b1;
    tick();
    capture(300, -1);
    cnt_busy = 0; cnt_ld = 0; cnt_late = 0;
    for (int i = 0; i < 300; i++) begin
      if (s_busy[i] === 1'b1) cnt_busy++;
      if (s_ld[i] === 1'b1) cnt_ld++;
      if (i >= 100 && (s_busy[i] !== 1'b0 || s_tx[i] !== 1'b1)) cnt_late++;
    end
    n_cmp++; if (cnt_busy !== 100) begin n_err++; $display("FAIL oneshot_busy_cycles got %0d want 100", cnt_busy); end
    n_cmp++; if (cnt_ld !== 1) begin n_err++; $display("FAIL oneshot_line_done_count got %0d want 1", cnt_ld); end
    n_cmp++; if (cnt_late !== 0) begin n_err++; $display("FAIL oneshot_idle_after got %0d active cycles want 0", cnt_late); end
    m_if.enable = 1'b0;
    tick();
    m_if.enable = 1'b1;
    tick();
    n_cmp++; if (m_if.tx !== 1'b0 || m_if.busy !== 1'b1) begin n_err++; $display("FAIL oneshot_rearm got tx=%b busy=%b want tx=0 busy=1", m_if.tx, m_if.busy); end
    n_cmp++; if (m_if.word !== 8'h61) begin n_err++; $display("FAIL oneshot_rearm_word got %h want 61", m_if.word); end
    m_if.one_shot = 1'b0;
  endtask

  task automatic test_abort();
    logic [23:0] obs;
    int          cnt_active, cnt_ld;
    do_reset();
    m_if.enable = 1'b1;
    tick();
    capture(140, 25);
    obs = obs_frame(20, 20);
    n_cmp++; if (obs !== dbl(fr_b, 10)) begin n_err++; $display("FAIL abort_b_frame got %h want %h", obs, dbl(fr_b, 10)); end
    n_cmp++; if (s_busy[39] !== 1'b1) begin n_err++; $display("FAIL abort_busy_last_stop got %b want 1", s_busy[39]); end
    cnt_active = 0; cnt_ld = 0;
    for (int i = 0; i < 140; i++) begin
      if (s_ld[i] === 1'b1) cnt_ld++;
      if (i >= 40 && (s_busy[i] !== 1'b0 || s_tx[i] !== 1'b1)) cnt_active++;
    end
    n_cmp++; if (cnt_active !== 0) begin n_err++; $display("FAIL abort_idle_after got %0d active cycles want 0", cnt_active); end
    n_cmp++; if (cnt_ld !== 0) begin n_err++; $display("FAIL abort_line_done_count got %0d want 0", cnt_ld); end
    m_if.enable = 1'b1;
    tick();
    capture(20, -1);
    obs = obs_frame(0, 20);
    n_cmp++; if (obs !== dbl(fr_a, 10)) begin n_err++; $display("FAIL abort_restart_frame got %h want %h", obs, dbl(fr_a, 10)); end
    n_cmp++; if (s_word[0] !== 8'h61) begin n_err++; $display("FAIL abort_restart_word got %h want 61", s_word[0]); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    m_if.enable = 1'b1;
    tick();
    capture(58, -1);
    n_cmp++; if (m_if.tx !== 1'b1 || m_if.word !== 8'h63) begin n_err++; $display("FAIL midrst_pre got tx=%b word=%h want tx=1 word=63", m_if.tx, m_if.word); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (m_if.tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b want 1", m_if.tx); end
    n_cmp++; if (m_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", m_if.busy); end
    n_cmp++; if (m_if.word !== 8'h00) begin n_err++; $display("FAIL midrst_word got %h want 00", m_if.word); end
    n_cmp++; if (m_if.line_done !== 1'b0) begin n_err++; $display("FAIL midrst_line_done got %b want 0", m_if.line_done); end
    tick();
    n_cmp++; if (m_if.tx !== 1'b0 || m_if.busy !== 1'b1) begin n_err++; $display("FAIL midrst_restart got tx=%b busy=%b want tx=0 busy=1", m_if.tx, m_if.busy); end
    n_cmp++; if (m_if.word !== 8'h61) begin n_err++; $display("FAIL midrst_restart_word got %h want 61", m_if.word); end
  endtask

  initial begin
    // start bit, data LSB first, [parity], stop bit(s)
    fr_a   = 12'b00_0100001101;
    fr_b   = 12'b00_0010001101;
    fr_c   = 12'b00_0110001101;
    fr_cr  = 12'b00_0101100001;
    fr_lf  = 12'b00_0010100001;
    fr_8e2 = 12'b010000110111;
    fr_8o2 = 12'b010000110011;
    fr_7e2 = 12'b001000011111;

    test_reset();
    test_single_frame();
    test_full_line();
    test_parity();
    test_one_shot();
    test_abort();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
